wb_trace_checker: RTL and testbench

- Consumer of the CPU's writeback debug trace: debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_addr and debug_wb_rf_wdata.
- Buffers an expected ("golden") trace, supplied through a valid/ready stream, in an internal FIFO.
- Compares every retired register write against the FIFO head. Latches the first divergence and reports pass/fail when the program reaches a terminal PC.
- Sits beside CPU in the simulation/FPGA top. It is synthesizable so it can run on-board.

---
 rtl/wb_trace_checker.sv | 155 +++++++++++++++
 tb/tb_wb_trace_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback trace checker. It compares each retired register write from the CPU
// against a golden trace held in a FIFO, and reports pass/fail when the CPU reaches END_PC.
module wb_trace_checker #(
   parameter int          DEPTH  = 8,
   parameter int          CNT_W  = 32,
   parameter logic [31:0] END_PC = 32'h0000_00FC
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [31:0]              debug_wb_pc,
   input  logic                     debug_wb_rf_wen,
   input  logic [4:0]               debug_wb_rf_addr,
   input  logic [31:0]              debug_wb_rf_wdata,
   input  logic                     check_en,
   input  logic                     gold_valid,
   output logic                     gold_ready,
   input  logic [31:0]              gold_pc,
   input  logic [4:0]               gold_addr,
   input  logic [31:0]              gold_wdata,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic [1:0]               err_code,
   output logic [31:0]              err_pc,
   output logic [31:0]              err_got,
   output logic [31:0]              err_exp,
   output logic [CNT_W-1:0]         match_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   // state  | meaning
   // IDLE   | loading golden entries, trace ignored, waiting for check_en
   // RUN    | comparing trace events against the FIFO head
   // PASS   | END_PC reached with FIFO drained (terminal)
   // FAIL   | mismatch, underflow or leftover entries (terminal)
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);

   state_t              state_q, state_d;
   logic [31:0]         mem_pc   [DEPTH];
   logic [4:0]          mem_addr [DEPTH];
   logic [31:0]         mem_data [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [AW:0]         level_q, level_d;
   logic [1:0]          err_code_q, err_code_d;
   logic [31:0]         err_pc_q, err_pc_d, err_got_q, err_got_d, err_exp_q, err_exp_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                push, pop, trace_ev, head_hit, fail_now;

   assign gold_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) && (level_q != LVL_FULL);
   assign push       = gold_valid && gold_ready;
   assign trace_ev   = debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);
   assign rd_next    = rd_ptr_q + AW'(1);
   assign head_hit   = (mem_pc[rd_ptr_q] == debug_wb_pc) &&
                       (mem_addr[rd_ptr_q] == debug_wb_rf_addr) &&
                       (mem_data[rd_ptr_q] == debug_wb_rf_wdata);

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      fail_now   = 1'b0;
      err_code_d = err_code_q;
      err_pc_d   = err_pc_q;
      err_got_d  = err_got_q;
      err_exp_d  = err_exp_q;
      case (state_q)
         S_IDLE: if (check_en) state_d = S_RUN;
         S_RUN: begin
            // A same-cycle push is never bypassed to the compare, so an empty FIFO underflows.
            if (trace_ev) begin
               if (level_q == '0) begin
                  fail_now   = 1'b1;
                  err_code_d = 2'd2;
                  err_exp_d  = 32'd0;
               end else if (head_hit) begin
                  pop = 1'b1;
               end else begin
                  fail_now   = 1'b1;
                  err_code_d = 2'd1;
                  err_exp_d  = mem_data[rd_ptr_q];
               end
            end
            if (fail_now) begin
               state_d   = S_FAIL;
               err_pc_d  = debug_wb_pc;
               err_got_d = debug_wb_rf_wdata;
            end else if (debug_wb_pc == END_PC) begin
               if ((level_q == '0) || (pop && (level_q == LVL_ONE))) begin
                  state_d = S_PASS;
               end else begin
                  state_d    = S_FAIL;
                  err_code_d = 2'd3;
                  err_pc_d   = debug_wb_pc;
                  err_got_d  = debug_wb_rf_wdata;
                  err_exp_d  = pop ? mem_data[rd_next] : mem_data[rd_ptr_q];
               end
            end
         end
         default: state_d = state_q;
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_next : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) level_d = level_q + LVL_ONE;
      if (pop && !push) level_d = level_q - LVL_ONE;
      cnt_d = (pop && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         err_code_q <= '0;
         err_pc_q   <= '0;
         err_got_q  <= '0;
         err_exp_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         err_code_q <= err_code_d;
         err_pc_q   <= err_pc_d;
         err_got_q  <= err_got_d;
         err_exp_q  <= err_exp_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= gold_pc;
         mem_addr[wr_ptr_q] <= gold_addr;
         mem_data[wr_ptr_q] <= gold_wdata;
      end
   end

   assign done       = (state_q == S_PASS) || (state_q == S_FAIL);
   assign pass       = (state_q == S_PASS);
   assign fail       = (state_q == S_FAIL);
   assign err_code   = err_code_q;
   assign err_pc     = err_pc_q;
   assign err_got    = err_got_q;
   assign err_exp    = err_exp_q;
   assign match_cnt  = cnt_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: a vector table for the basic pass flow
// plus hand sequences for mismatch, underflow, FIFO wrap, leftover entries and reset.
module tb_wb_trace_checker;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] debug_wb_pc;
   logic        debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_addr;
   logic [31:0] debug_wb_rf_wdata;
   logic        check_en;
   logic        gold_valid;
   logic        gold_ready;
   logic [31:0] gold_pc;
   logic [4:0]  gold_addr;
   logic [31:0] gold_wdata;
   logic        done, pass, fail;
   logic [1:0]  err_code;
   logic [31:0] err_pc, err_got, err_exp;
   logic [31:0] match_cnt;
   logic [3:0]  fifo_level;

   int n_tests = 0;
   int n_fail  = 0;

   wb_trace_checker #(.DEPTH(8), .CNT_W(32), .END_PC(32'h0000_00FC)) dut (
      .clk(clk), .resetn(resetn),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .check_en(check_en), .gold_valid(gold_valid), .gold_ready(gold_ready),
      .gold_pc(gold_pc), .gold_addr(gold_addr), .gold_wdata(gold_wdata),
      .done(done), .pass(pass), .fail(fail), .err_code(err_code),
      .err_pc(err_pc), .err_got(err_got), .err_exp(err_exp),
      .match_cnt(match_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gv;
      logic [31:0] gpc;
      logic [4:0]  ga;
      logic [31:0] gd;
      logic        en;
      logic        wen;
      logic [31:0] pc;
      logic [4:0]  a;
      logic [31:0] d;
      int          lvl;
      int          cnt;
      logic        rdy;
      logic        dn;
      logic        ps;
      logic        fl;
   } vec_t;

   vec_t tbl[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic drive_idle();
      check_en          = 1'b0;
      gold_valid        = 1'b0;
      gold_pc           = 32'd0;
      gold_addr         = 5'd0;
      gold_wdata        = 32'd0;
      debug_wb_pc       = 32'd0;
      debug_wb_rf_wen   = 1'b0;
      debug_wb_rf_addr  = 5'd0;
      debug_wb_rf_wdata = 32'd0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive_idle();
      step();
      resetn = 1'b1;
   endtask

   task automatic push(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
      gold_valid = 1'b1; gold_pc = p; gold_addr = a; gold_wdata = d;
      step();
      gold_valid = 1'b0;
   endtask

   task automatic ev(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
      debug_wb_rf_wen = 1'b1; debug_wb_pc = p; debug_wb_rf_addr = a; debug_wb_rf_wdata = d;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_pass"}, 32'(pass), 32'd0);
      chk({nm, "_fail"}, 32'(fail), 32'd0);
      chk({nm, "_code"}, 32'(err_code), 32'd0);
      chk({nm, "_errpc"}, err_pc, 32'd0);
      chk({nm, "_errgot"}, err_got, 32'd0);
      chk({nm, "_errexp"}, err_exp, 32'd0);
      chk({nm, "_cnt"}, match_cnt, 32'd0);
      chk({nm, "_lvl"}, 32'(fifo_level), 32'd0);
      chk({nm, "_rdy"}, 32'(gold_ready), 32'd1);
   endtask

   initial begin
      int lvl, npush, npop, cyc;
      logic acc, popm;

      // gv  gpc    ga gd     en wen pc     a  d     lvl cnt rdy dn ps fl
      tbl[0]  = '{1'b1, 32'h10, 5'd1, 32'd5,  1'b0, 1'b0, 32'h0,  5'd0, 32'd0,  1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 32'h14, 5'd2, 32'd7,  1'b0, 1'b0, 32'h0,  5'd0, 32'd0,  2, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 32'h18, 5'd3, 32'd12, 1'b0, 1'b0, 32'h0,  5'd0, 32'd0,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b1, 32'h10, 5'd1, 32'd5,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b1, 1'b0, 32'h0,  5'd0, 32'd0,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b1, 32'h10, 5'd0, 32'd5,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b0, 32'h10, 5'd1, 32'd5,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b1, 32'h10, 5'd1, 32'd5,  2, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b1, 32'h14, 5'd2, 32'd7,  1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b1, 32'h18, 5'd3, 32'd12, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b0, 32'hFC, 5'd0, 32'd0,  0, 3, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 32'h0,  5'd0, 32'd0,  1'b0, 1'b0, 32'h0,  5'd0, 32'd0,  0, 3, 1'b0, 1'b1, 1'b1, 1'b0};

      resetn = 1'b0;
      drive_idle();
      step();
      step();
      chk_all_zero("reset");
      resetn = 1'b1;

      // pass flow with ignored r0 / wen=0 / IDLE events
      for (int i = 0; i < 12; i++) begin
         gold_valid = tbl[i].gv; gold_pc = tbl[i].gpc; gold_addr = tbl[i].ga; gold_wdata = tbl[i].gd;
         check_en = tbl[i].en; debug_wb_rf_wen = tbl[i].wen; debug_wb_pc = tbl[i].pc;
         debug_wb_rf_addr = tbl[i].a; debug_wb_rf_wdata = tbl[i].d;
         step();
         chk($sformatf("v%0d_lvl", i), 32'(fifo_level), 32'(tbl[i].lvl));
         chk($sformatf("v%0d_cnt", i), match_cnt, 32'(tbl[i].cnt));
         chk($sformatf("v%0d_rdy", i), 32'(gold_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
         chk($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].ps));
         chk($sformatf("v%0d_fail", i), 32'(fail), 32'(tbl[i].fl));
      end

      // mismatch on write data
      do_reset();
      push(32'h10, 5'd1, 32'd5);
      check_en = 1'b1; step(); check_en = 1'b0;
      ev(32'h10, 5'd1, 32'd6);
      step();
      chk("mm_fail", 32'(fail), 32'd1);
      chk("mm_code", 32'(err_code), 32'd1);
      chk("mm_errpc", err_pc, 32'h10);
      chk("mm_errgot", err_got, 32'd6);
      chk("mm_errexp", err_exp, 32'd5);
      chk("mm_cnt", match_cnt, 32'd0);
      chk("mm_rdy", 32'(gold_ready), 32'd0);
      chk("mm_lvl", 32'(fifo_level), 32'd1);
      ev(32'h20, 5'd2, 32'd9);
      step();
      chk("mm_frozen_pc", err_pc, 32'h10);
      chk("mm_frozen_got", err_got, 32'd6);
      chk("mm_frozen_pass", 32'(pass), 32'd0);

      // underflow with a same-cycle push
      do_reset();
      check_en = 1'b1; step(); check_en = 1'b0;
      ev(32'h20, 5'd4, 32'd1);
      gold_valid = 1'b1; gold_pc = 32'h20; gold_addr = 5'd4; gold_wdata = 32'd1;
      step();
      drive_idle();
      chk("uf_fail", 32'(fail), 32'd1);
      chk("uf_code", 32'(err_code), 32'd2);
      chk("uf_errexp", err_exp, 32'd0);
      chk("uf_errpc", err_pc, 32'h20);
      chk("uf_errgot", err_got, 32'd1);
      chk("uf_lvl", 32'(fifo_level), 32'd1);
      chk("uf_cnt", match_cnt, 32'd0);

      // fill to DEPTH, then match 12 entries while refilling across the wrap
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push(32'h100 + 32'(4 * i), 5'(i + 1), 32'hA000 + 32'(3 * i));
         chk($sformatf("fill%0d_lvl", i), 32'(fifo_level), 32'(i + 1));
      end
      chk("full_rdy", 32'(gold_ready), 32'd0);
      push(32'h120, 5'd9, 32'hA018);
      chk("full_lvl", 32'(fifo_level), 32'd8);
      check_en = 1'b1; step(); check_en = 1'b0;
      lvl = 8; npush = 8; npop = 0; cyc = 0;
      while (npop < 12 && cyc < 40) begin
         acc  = (npush < 12) && (lvl < 8);
         popm = (lvl > 0);
         gold_valid = (npush < 12);
         gold_pc = 32'h100 + 32'(4 * npush); gold_addr = 5'(npush + 1); gold_wdata = 32'hA000 + 32'(3 * npush);
         if (popm) ev(32'h100 + 32'(4 * npop), 5'(npop + 1), 32'hA000 + 32'(3 * npop));
         else debug_wb_rf_wen = 1'b0;
         step();
         if (acc) npush++;
         if (popm) npop++;
         lvl = lvl + (acc ? 1 : 0) - (popm ? 1 : 0);
         chk($sformatf("wrap%0d_lvl", cyc), 32'(fifo_level), 32'(lvl));
         cyc++;
      end
      drive_idle();
      chk("wrap_pops", 32'(npop), 32'd12);
      chk("wrap_cnt", match_cnt, 32'd12);
      chk("wrap_fail", 32'(fail), 32'd0);
      debug_wb_pc = 32'hFC;
      step();
      debug_wb_pc = 32'h0;
      chk("wrap_pass", 32'(pass), 32'd1);

      // leftover entry at END_PC, then reset mid-run
      do_reset();
      push(32'h40, 5'd5, 32'hAA);
      push(32'h44, 5'd6, 32'hBB);
      check_en = 1'b1; step(); check_en = 1'b0;
      ev(32'h40, 5'd5, 32'hAA);
      step();
      chk("lo_cnt", match_cnt, 32'd1);
      chk("lo_lvl1", 32'(fifo_level), 32'd1);
      drive_idle();
      debug_wb_pc = 32'hFC;
      step();
      chk("lo_fail", 32'(fail), 32'd1);
      chk("lo_code", 32'(err_code), 32'd3);
      chk("lo_errpc", err_pc, 32'hFC);
      chk("lo_pass", 32'(pass), 32'd0);
      resetn = 1'b0;
      drive_idle();
      step();
      chk_all_zero("rst_mid");
      resetn = 1'b1;
      ev(32'h50, 5'd7, 32'd3);
      step();
      drive_idle();
      chk("idle_after_rst_fail", 32'(fail), 32'd0);
      chk("idle_after_rst_done", 32'(done), 32'd0);

      // reset while in RUN with entries buffered
      push(32'h60, 5'd8, 32'd4);
      check_en = 1'b1; step(); check_en = 1'b0;
      resetn = 1'b0;
      step();
      chk_all_zero("rst_run");
      resetn = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
